gb_apu_channel_pulse_gen: RTL and testbench
===========================================

GB_APU_CHANNEL_PULSE_GEN -- requirements
Module: gb_apu_channel_pulse_gen

Interface
REQ-001 SHALL have parameter FREQ_W, default 11, frequency/timer width (>=4).
REQ-002 SHALL have parameter LEN_W, default 6, length field width (>=2).
REQ-003 SHALL have parameter VOL_W, default 4, volume and level width (>=2).
REQ-004 SHALL have parameter TIMER_DIV, default 4, clk cycles per frequency-timer increment (>=1).
REQ-005 SHALL have the following ports; one clock domain, reset synchronous active-high.
 clk  in  1  system clock
 reset  in  1  synchronous active-high reset
 clk_length_ctr / clk_vol_env / clk_sweep  in  1 each  single-cycle frame-sequencer tick strobes
 sweep_time  in  3  sweep pace; 0 = sweep stepping off
 sweep_decreasing  in  1  sweep direction
 num_sweep_shifts  in  3  sweep shift n
 wave_duty  in  2  duty select
 length  in  LEN_W  length load value
 initial_volume  in  VOL_W  envelope start volume
 envelope_increasing  in  1  envelope direction
 num_envelope_sweeps  in  3  envelope pace; 0 = frozen
 start  in  1  trigger strobe
 single  in  1  1 = length counter enabled
 frequency  in  FREQ_W  period value
 level  out  VOL_W  sample output
 enable  out  1  channel active

Function
REQ-006 SHALL, on start=1 at a clk edge: enable<=1, len_rem<=2^LEN_W-length, vol<=initial_volume, env_cnt<=num_envelope_sweeps, shadow<=frequency, sweep_cnt<=sweep_time, timer<=frequency, div<=0, step<=0.
REQ-007 SHALL hold enable at 0 on trigger when initial_volume==0 and envelope_increasing==0 (DAC off).
REQ-008 SHALL increment div every clk while enable=1; at div==TIMER_DIV-1, div<=0 and timer increments; at timer all-ones, timer<=shadow and step<=step+1 mod 8.
REQ-009 SHALL use duty patterns (step 0..7): 00=00000001, 01=10000001, 10=10000111, 11=01111110.
REQ-010 SHALL drive level = vol when enable=1 and pattern bit[step]=1, else 0, combinationally from registered state.
REQ-011 SHALL, on clk_length_ctr with single=1 and enable=1, decrement len_rem; len_rem reaching 0 clears enable; single=0 freezes len_rem.
REQ-012 SHALL, on clk_vol_env with num_envelope_sweeps!=0: env_cnt==1 -> env_cnt reload, vol +/-1 saturating at 2^VOL_W-1 / 0; else env_cnt decrements.
REQ-013 SHALL treat start coincident with any tick strobe as trigger only; the tick is dropped.
REQ-014 SHALL continue envelope and duty stepping only while enable=1; enable=0 forces level=0.
REQ-015 SHALL re-trigger mid-note by fully reloading per REQ-006.

Reset
REQ-016 SHALL, on reset=1, clear all state: enable=0, level=0, vol=0, step=0, div=0, timer=0, shadow=0, counters=0; reset overrides start and all strobes.

Configuration
REQ-017 SHALL compile sweep logic only when GB_APU_PULSE_SWEEP_EN is defined.
REQ-018 With GB_APU_PULSE_SWEEP_EN: on clk_sweep with sweep_time!=0, sweep_cnt==1 -> reload, new=shadow +/- (shadow>>num_sweep_shifts); increasing and new>2^FREQ_W-1 clears enable; otherwise shadow<=new when num_sweep_shifts!=0; else sweep_cnt decrements.
REQ-019 With GB_APU_PULSE_SWEEP_EN: trigger with sweep_decreasing=0, num_sweep_shifts!=0 and frequency+(frequency>>shifts) overflowing SHALL leave enable=0.
REQ-020 Without GB_APU_PULSE_SWEEP_EN: sweep ports and clk_sweep ignored; timer reload uses live frequency input instead of shadow.

Verification
REQ-021 Defaults, frequency=2047, wave_duty=10, initial_volume=1, trigger: level pattern repeats every 32 clk, high 16 of 32 clk, level=1.
REQ-022 single=1, length=1, trigger, 63 clk_length_ctr ticks: enable=1 after tick 62, 0 after tick 63; length=63 -> 0 after tick 1.
REQ-023 initial_volume=1, envelope_increasing=1, num_envelope_sweeps=7, 98 clk_vol_env ticks: vol=15 after tick 98, stays 15 on further ticks.
REQ-024 SWEEP_EN, frequency=2047, sweep_decreasing=1, shifts=7, sweep_time=7, 7 clk_sweep ticks: shadow=2032, enable=1.
REQ-025 SWEEP_EN, frequency=2047, sweep_decreasing=0, shifts=1, trigger: enable stays 0, level=0.
REQ-026 reset asserted mid-note with start=1 same cycle: enable=0, level=0 next cycle.

Source files
------------

// File: rtl/gb_apu_channel_pulse_gen.sv
// Game Boy APU pulse (square) channel generator.
//
// Produces a duty-cycled square wave whose amplitude follows a volume envelope,
// with an optional length counter and, when GB_APU_PULSE_SWEEP_EN is defined,
// a frequency sweep unit. Without the macro the sweep ports are ignored and the
// frequency timer reloads from the live frequency input.
//
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   clk_length_ctr/clk_vol_env/clk_sweep  single-cycle frame-sequencer ticks
//   sweep_time, sweep_decreasing, num_sweep_shifts  sweep controls
//   wave_duty                         duty pattern select
//   length                            length load value (counts 2^LEN_W - length)
//   initial_volume, envelope_increasing, num_envelope_sweeps  envelope controls
//   start                             trigger strobe
//   single                            length counter enable
//   frequency                         timer period value
//   level                             sample output (volume or 0)
//   enable                            channel active
module gb_apu_channel_pulse_gen #(
  parameter int unsigned FREQ_W    = 11,
  parameter int unsigned LEN_W     = 6,
  parameter int unsigned VOL_W     = 4,
  parameter int unsigned TIMER_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_length_ctr,
  input  logic              clk_vol_env,
  input  logic              clk_sweep,
  input  logic [2:0]        sweep_time,
  input  logic              sweep_decreasing,
  input  logic [2:0]        num_sweep_shifts,
  input  logic [1:0]        wave_duty,
  input  logic [LEN_W-1:0]  length,
  input  logic [VOL_W-1:0]  initial_volume,
  input  logic              envelope_increasing,
  input  logic [2:0]        num_envelope_sweeps,
  input  logic              start,
  input  logic              single,
  input  logic [FREQ_W-1:0] frequency,
  output logic [VOL_W-1:0]  level,
  output logic              enable
);

  localparam int unsigned DivW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [DivW-1:0]  DivLast = DivW'(TIMER_DIV - 1);
  localparam logic [VOL_W-1:0] VolMax  = '1;

  logic              enable_q, enable_d;
  logic [LEN_W:0]    len_rem_q, len_rem_d;  // one extra bit: length=0 loads 2^LEN_W
  logic [VOL_W-1:0]  vol_q, vol_d;
  logic [2:0]        env_cnt_q, env_cnt_d;
  logic [FREQ_W-1:0] timer_q, timer_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [2:0]        step_q, step_d;
  logic [7:0]        duty_pattern;

  // Sweep interface to the main next-state logic.
  logic [FREQ_W-1:0] reload_freq;
  logic              sweep_kill;
  logic              trig_block;

`ifdef GB_APU_PULSE_SWEEP_EN
  logic [FREQ_W-1:0] shadow_q, shadow_d;
  logic [2:0]        sweep_cnt_q, sweep_cnt_d;
  logic [FREQ_W:0]   sweep_delta, sweep_new, trig_sum;

  assign reload_freq = shadow_q;

  always_comb begin
    sweep_delta = {1'b0, shadow_q >> num_sweep_shifts};
    sweep_new   = sweep_decreasing ? ({1'b0, shadow_q} - sweep_delta)
                                   : ({1'b0, shadow_q} + sweep_delta);
    trig_sum    = {1'b0, frequency} + {1'b0, frequency >> num_sweep_shifts};
    // A trigger whose very first sweep step would overflow never starts.
    trig_block  = !sweep_decreasing && (num_sweep_shifts != 3'd0) && trig_sum[FREQ_W];

    shadow_d    = shadow_q;
    sweep_cnt_d = sweep_cnt_q;
    sweep_kill  = 1'b0;
    if (start) begin
      shadow_d    = frequency;
      sweep_cnt_d = sweep_time;
    end else if (enable_q && clk_sweep && (sweep_time != 3'd0)) begin
      if (sweep_cnt_q == 3'd1) begin
        sweep_cnt_d = sweep_time;
        if (!sweep_decreasing && sweep_new[FREQ_W]) begin
          sweep_kill = 1'b1;
        end else if (num_sweep_shifts != 3'd0) begin
          shadow_d = sweep_new[FREQ_W-1:0];
        end
      end else begin
        sweep_cnt_d = sweep_cnt_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q    <= '0;
      sweep_cnt_q <= '0;
    end else begin
      shadow_q    <= shadow_d;
      sweep_cnt_q <= sweep_cnt_d;
    end
  end
`else
  logic unused_sweep_inputs;
  assign unused_sweep_inputs = ^{clk_sweep, sweep_time, sweep_decreasing, num_sweep_shifts};
  assign reload_freq = frequency;
  assign sweep_kill  = 1'b0;
  assign trig_block  = 1'b0;
`endif

  // Pattern bit n is the output for duty step n.
  always_comb begin
    duty_pattern = 8'b1000_0000;
    unique case (wave_duty)
      2'b00: duty_pattern = 8'b1000_0000;
      2'b01: duty_pattern = 8'b1000_0001;
      2'b10: duty_pattern = 8'b1110_0001;
      2'b11: duty_pattern = 8'b0111_1110;
      default: duty_pattern = 8'b1000_0000;
    endcase
  end

  assign level  = (enable_q && duty_pattern[step_q]) ? vol_q : '0;
  assign enable = enable_q;

  always_comb begin
    enable_d  = enable_q;
    len_rem_d = len_rem_q;
    vol_d     = vol_q;
    env_cnt_d = env_cnt_q;
    timer_d   = timer_q;
    div_d     = div_q;
    step_d    = step_q;

    if (start) begin
      // Trigger wins over any coincident tick; those ticks are dropped.
      enable_d  = !((initial_volume == '0) && !envelope_increasing) && !trig_block;
      len_rem_d = {1'b1, {LEN_W{1'b0}}} - {1'b0, length};
      vol_d     = initial_volume;
      env_cnt_d = num_envelope_sweeps;
      timer_d   = frequency;
      div_d     = '0;
      step_d    = 3'd0;
    end else if (enable_q) begin
      if (div_q == DivLast) begin
        div_d = '0;
        if (timer_q == '1) begin
          timer_d = reload_freq;
          step_d  = step_q + 3'd1;
        end else begin
          timer_d = timer_q + FREQ_W'(1);
        end
      end else begin
        div_d = div_q + DivW'(1);
      end

      if (clk_length_ctr && single && (len_rem_q != '0)) begin
        len_rem_d = len_rem_q - (LEN_W + 1)'(1);
        if (len_rem_q == (LEN_W + 1)'(1)) begin
          enable_d = 1'b0;
        end
      end

      if (clk_vol_env && (num_envelope_sweeps != 3'd0)) begin
        if (env_cnt_q == 3'd1) begin
          env_cnt_d = num_envelope_sweeps;
          if (envelope_increasing) begin
            if (vol_q != VolMax) vol_d = vol_q + VOL_W'(1);
          end else begin
            if (vol_q != '0) vol_d = vol_q - VOL_W'(1);
          end
        end else begin
          env_cnt_d = env_cnt_q - 3'd1;
        end
      end

      if (sweep_kill) begin
        enable_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q  <= 1'b0;
      len_rem_q <= '0;
      vol_q     <= '0;
      env_cnt_q <= '0;
      timer_q   <= '0;
      div_q     <= '0;
      step_q    <= '0;
    end else begin
      enable_q  <= enable_d;
      len_rem_q <= len_rem_d;
      vol_q     <= vol_d;
      env_cnt_q <= env_cnt_d;
      timer_q   <= timer_d;
      div_q     <= div_d;
      step_q    <= step_d;
    end
  end

endmodule

// File: tb/tb_gb_apu_channel_pulse_gen.sv
// Self-checking bench for gb_apu_channel_pulse_gen (default parameters).
// A cycles-until-next-step reference model predicts enable and level every cycle;
// directed steps cover duty period, length, envelope saturation, DAC-off, reset.
module tb_gb_apu_channel_pulse_gen;

  localparam int FreqW = 11;
  localparam int LenW  = 6;
  localparam int VolW  = 4;
  localparam int Div   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             clk_length_ctr, clk_vol_env, clk_sweep;
  logic [2:0]       sweep_time;
  logic             sweep_decreasing;
  logic [2:0]       num_sweep_shifts;
  logic [1:0]       wave_duty;
  logic [LenW-1:0]  length;
  logic [VolW-1:0]  initial_volume;
  logic             envelope_increasing;
  logic [2:0]       num_envelope_sweeps;
  logic             start;
  logic             single;
  logic [FreqW-1:0] frequency;
  logic [VolW-1:0]  level;
  logic             enable;

  gb_apu_channel_pulse_gen #(
    .FREQ_W(FreqW), .LEN_W(LenW), .VOL_W(VolW), .TIMER_DIV(Div)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .clk_length_ctr      (clk_length_ctr),
    .clk_vol_env         (clk_vol_env),
    .clk_sweep           (clk_sweep),
    .sweep_time          (sweep_time),
    .sweep_decreasing    (sweep_decreasing),
    .num_sweep_shifts    (num_sweep_shifts),
    .wave_duty           (wave_duty),
    .length              (length),
    .initial_volume      (initial_volume),
    .envelope_increasing (envelope_increasing),
    .num_envelope_sweeps (num_envelope_sweeps),
    .start               (start),
    .single              (single),
    .frequency           (frequency),
    .level               (level),
    .enable              (enable)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: duty step advances after m_left enabled clocks.
  int m_en, m_len, m_vol, m_env, m_step, m_left, m_trig_freq;
  string duty_str[4] = '{"00000001", "10000001", "10000111", "01111110"};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_level();
    if (m_en != 0 && duty_str[int'(wave_duty)].getc(m_step) == "1") return m_vol;
    return 0;
  endfunction

  function automatic int reload_src();
`ifdef GB_APU_PULSE_SWEEP_EN
    return m_trig_freq;
`else
    return int'(frequency);
`endif
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_en = 0; m_len = 0; m_vol = 0; m_env = 0; m_step = 0; m_left = 0;
    end else if (start) begin
      m_en = (initial_volume == 0 && !envelope_increasing) ? 0 : 1;
`ifdef GB_APU_PULSE_SWEEP_EN
      if (!sweep_decreasing && num_sweep_shifts != 0 &&
          int'(frequency) + (int'(frequency) >> num_sweep_shifts) > 2 ** FreqW - 1) m_en = 0;
`endif
      m_len = 2 ** LenW - int'(length);
      m_vol = int'(initial_volume);
      m_env = int'(num_envelope_sweeps);
      m_step = 0;
      m_trig_freq = int'(frequency);
      m_left = (2 ** FreqW - int'(frequency)) * Div;
    end else if (m_en != 0) begin
      m_left--;
      if (m_left == 0) begin
        m_step = (m_step + 1) % 8;
        m_left = (2 ** FreqW - reload_src()) * Div;
      end
      if (clk_length_ctr && single) begin
        m_len--;
        if (m_len == 0) m_en = 0;
      end
      if (clk_vol_env && num_envelope_sweeps != 0) begin
        if (m_env == 1) begin
          m_env = int'(num_envelope_sweeps);
          if (envelope_increasing) m_vol = (m_vol < 2 ** VolW - 1) ? m_vol + 1 : m_vol;
          else m_vol = (m_vol > 0) ? m_vol - 1 : 0;
        end else begin
          m_env = (m_env + 7) % 8;
        end
      end
    end
  endtask

  // One clock: update model at the edge, compare just after it, return at negedge.
  task automatic cycle(input bit do_chk);
    @(posedge clk);
    model_edge();
    #1;
    if (do_chk) begin
      chk("enable", {31'd0, enable}, m_en);
      chk("level", {28'd0, level}, exp_level());
    end
    @(negedge clk);
  endtask

  task automatic tick_len();
    clk_length_ctr = 1'b1; cycle(1'b1);
    clk_length_ctr = 1'b0; cycle(1'b1);
  endtask

  task automatic tick_env();
    clk_vol_env = 1'b1; cycle(1'b1);
    clk_vol_env = 1'b0; cycle(1'b1);
  endtask

  task automatic trigger();
    start = 1'b1; cycle(1'b1);
    start = 1'b0;
  endtask

  initial begin
    logic [3:0] lv[32];
    int highs, rep, mx;

    reset = 1'b1; start = 1'b1;
    clk_length_ctr = 1'b0; clk_vol_env = 1'b0; clk_sweep = 1'b0;
    sweep_time = 3'd0; sweep_decreasing = 1'b1; num_sweep_shifts = 3'd0;
    wave_duty = 2'd2; length = '0; initial_volume = 4'd1; envelope_increasing = 1'b0;
    num_envelope_sweeps = 3'd0; single = 1'b0; frequency = 11'd2047;
    @(negedge clk);

    // Reset dominates a coincident trigger.
    cycle(1'b1); cycle(1'b1);
    chk("reset_enable", {31'd0, enable}, 0);
    chk("reset_level", {28'd0, level}, 0);
    reset = 1'b0; start = 1'b0;

    // Fastest period, 50% duty: 32-clock period, 16 clocks high at level 1.
    trigger();
    highs = 0;
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1);
      lv[i] = level;
      if (level == 4'd1) highs++;
    end
    chk("duty_high_count", highs, 16);
    rep = 0;
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1);
      if (level !== lv[i]) rep++;
    end
    chk("duty_period_32", rep, 0);

    // Length counter: length=1 -> 63 ticks to expire.
    single = 1'b1; length = 6'd1; initial_volume = 4'd5;
    trigger();
    for (int t = 1; t <= 63; t++) begin
      tick_len();
      if (t == 62) chk("len_tick62_enable", {31'd0, enable}, 1);
    end
    chk("len_tick63_enable", {31'd0, enable}, 0);
    length = 6'd63;
    trigger();
    tick_len();
    chk("len63_one_tick", {31'd0, enable}, 0);

    // Tick coincident with trigger is dropped.
    start = 1'b1; clk_length_ctr = 1'b1; cycle(1'b1);
    start = 1'b0; clk_length_ctr = 1'b0; cycle(1'b1);
    chk("start_drops_tick", {31'd0, enable}, 1);
    tick_len();
    chk("len_after_dropped", {31'd0, enable}, 0);

    // Envelope climbs from 1 to 15 over 98 ticks and saturates.
    single = 1'b0; initial_volume = 4'd1; envelope_increasing = 1'b1;
    num_envelope_sweeps = 3'd7; wave_duty = 2'd3;
    trigger();
    for (int t = 0; t < 97; t++) tick_env();
    mx = 0;
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1);
      if (int'(level) > mx) mx = int'(level);
    end
    chk("env_vol_97", mx, 14);
    tick_env();
    mx = 0;
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1);
      if (int'(level) > mx) mx = int'(level);
    end
    chk("env_vol_98", mx, 15);
    for (int t = 0; t < 14; t++) tick_env();
    mx = 0;
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1);
      if (int'(level) > mx) mx = int'(level);
    end
    chk("env_vol_saturated", mx, 15);

    // DAC off: zero volume, decreasing envelope never starts.
    num_envelope_sweeps = 3'd0; initial_volume = 4'd0; envelope_increasing = 1'b0;
    trigger();
    chk("dac_off_enable", {31'd0, enable}, 0);
    envelope_increasing = 1'b1;
    trigger();
    chk("dac_inc_enable", {31'd0, enable}, 1);

    // Reset mid-note with a coincident trigger.
    initial_volume = 4'd9;
    trigger();
    reset = 1'b1; start = 1'b1; cycle(1'b1);
    chk("reset_mid_enable", {31'd0, enable}, 0);
    chk("reset_mid_level", {28'd0, level}, 0);
    reset = 1'b0; start = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      reset          = ($urandom_range(0, 399) == 0);
      start          = ($urandom_range(0, 59) == 0);
      clk_length_ctr = ($urandom_range(0, 7) == 0);
      clk_vol_env    = ($urandom_range(0, 7) == 0);
      clk_sweep      = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) begin
        frequency           = 11'(2048 - $urandom_range(1, 12));
        wave_duty           = 2'($urandom);
        initial_volume      = 4'($urandom);
        envelope_increasing = 1'($urandom);
        num_envelope_sweeps = 3'($urandom);
        single              = 1'($urandom);
        length              = 6'($urandom);
        sweep_decreasing    = 1'($urandom);
        num_sweep_shifts    = 3'($urandom);
      end
      cycle(1'b1);
    end
    reset = 1'b0; start = 1'b0;
    clk_length_ctr = 1'b0; clk_vol_env = 1'b0; clk_sweep = 1'b0;

`ifdef GB_APU_PULSE_SWEEP_EN
    // Overflowing first sweep step blocks the trigger.
    single = 1'b0; num_envelope_sweeps = 3'd0; initial_volume = 4'd5;
    frequency = 11'd2047; sweep_decreasing = 1'b0; num_sweep_shifts = 3'd1;
    trigger();
    chk("sweep_block_enable", {31'd0, enable}, 0);
    chk("sweep_block_level", {28'd0, level}, 0);
    // Decreasing sweep keeps the channel running.
    sweep_decreasing = 1'b1; num_sweep_shifts = 3'd7; sweep_time = 3'd7;
    start = 1'b1; cycle(1'b0); start = 1'b0;
    for (int t = 0; t < 7; t++) begin
      clk_sweep = 1'b1; cycle(1'b0);
      clk_sweep = 1'b0; cycle(1'b0);
    end
    chk("sweep_dec_enable", {31'd0, enable}, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
